// File: rtl/find_bw_left_edge.sv
// find_bw_left_edge: locates the lower edge of a signal's occupied bandwidth.
// Scans the bins for the peak, then walks left from the peak to the first bin
// more than THRESHOLD_DB below it, and reports the bracketing bin pair.
// Optional build macro FIND_BW_LEFT_EDGE_SNAPSHOT_EN: copy both input arrays
// on start acceptance so the inputs may change during the scan.
module find_bw_left_edge #(
  parameter int unsigned ACCUM_WIDTH    = 18,
  parameter int unsigned FREQ_BIN_WIDTH = 16,
  parameter int unsigned THRESHOLD_DB   = 7680,
  parameter int unsigned NUM_ACCUMS     = 24
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic signed [ACCUM_WIDTH-1:0]    accumulator_val_i [NUM_ACCUMS],
  input  logic        [FREQ_BIN_WIDTH-1:0] freq_bin_i        [NUM_ACCUMS],
  output logic        [FREQ_BIN_WIDTH-1:0] f1_o,
  output logic        [FREQ_BIN_WIDTH-1:0] f2_o,
  output logic signed [ACCUM_WIDTH-1:0]    L1_o,
  output logic signed [ACCUM_WIDTH-1:0]    L2_o,
  output logic                             valid_o,
  output logic                             busy_o
);

  localparam int unsigned IDX_W = (NUM_ACCUMS > 1) ? $clog2(NUM_ACCUMS) : 1;
  localparam int unsigned EXT_W = ACCUM_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCUMS - 1);
  localparam logic signed [EXT_W-1:0] THR_EXT = EXT_W'(THRESHOLD_DB);

  typedef enum logic [1:0] {IDLE, PEAK, SEARCH, DONE} state_t;

  state_t                          state_q, state_d;
  logic        [IDX_W-1:0]         idx_q, idx_m1;
  logic        [IDX_W-1:0]         peak_idx_q, peak_idx_nxt;
  logic        [IDX_W-1:0]         lo_idx_q, hi_idx_q;
  logic signed [ACCUM_WIDTH-1:0]   peak_q, peak_nxt, cur_acc;
  logic signed [EXT_W-1:0]         thr_q;
  logic                            start_ok, below;

  // Data source seen by the scan: live inputs or the start-time snapshot
  logic signed [ACCUM_WIDTH-1:0]    acc [NUM_ACCUMS];
  logic        [FREQ_BIN_WIDTH-1:0] frq [NUM_ACCUMS];

`ifdef FIND_BW_LEFT_EDGE_SNAPSHOT_EN
  logic signed [ACCUM_WIDTH-1:0]    acc_snap [NUM_ACCUMS];
  logic        [FREQ_BIN_WIDTH-1:0] frq_snap [NUM_ACCUMS];

  // Capture both input arrays when a start is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_ACCUMS); i++) begin
        acc_snap[i] <= '0;
        frq_snap[i] <= '0;
      end
    end else if (start_ok) begin
      for (int i = 0; i < int'(NUM_ACCUMS); i++) begin
        acc_snap[i] <= accumulator_val_i[i];
        frq_snap[i] <= freq_bin_i[i];
      end
    end
  end

  assign acc = acc_snap;
  assign frq = frq_snap;
`else
  assign acc = accumulator_val_i;
  assign frq = freq_bin_i;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus peak-update and threshold-crossing decodes
  always_comb begin
    state_d      = state_q;
    start_ok     = 1'b0;
    idx_m1       = '0;
    cur_acc      = acc[idx_q];
    peak_nxt     = peak_q;
    peak_idx_nxt = peak_idx_q;
    below        = 1'b0;

    if (idx_q != '0) idx_m1 = idx_q - IDX_W'(1);
    // Strictly greater keeps the lowest index on ties
    if (cur_acc > peak_q) begin
      peak_nxt     = cur_acc;
      peak_idx_nxt = idx_q;
    end
    below = ($signed({acc[idx_m1][ACCUM_WIDTH-1], acc[idx_m1]}) < thr_q);

    case (state_q)
      IDLE: begin
        // A start coinciding with the result strobe waits one cycle
        if (start_i && !valid_o) begin
          start_ok = 1'b1;
          state_d  = PEAK;
        end
      end
      PEAK:    if (idx_q == LAST_IDX) state_d = SEARCH;
      SEARCH:  if (idx_q == '0 || below) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan datapath and registered result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      peak_idx_q <= '0;
      peak_q     <= '0;
      thr_q      <= '0;
      lo_idx_q   <= '0;
      hi_idx_q   <= '0;
      f1_o       <= '0;
      f2_o       <= '0;
      L1_o       <= '0;
      L2_o       <= '0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            peak_q     <= accumulator_val_i[0];
            peak_idx_q <= '0;
            idx_q      <= IDX_W'(1);
            busy_o     <= 1'b1;
          end
        end
        PEAK: begin
          peak_q     <= peak_nxt;
          peak_idx_q <= peak_idx_nxt;
          if (idx_q == LAST_IDX) begin
            // One extra bit so a deep negative peak cannot wrap
            thr_q <= $signed({peak_nxt[ACCUM_WIDTH-1], peak_nxt}) - THR_EXT;
            idx_q <= peak_idx_nxt;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        SEARCH: begin
          if (idx_q == '0) begin
            lo_idx_q <= '0;
            hi_idx_q <= '0;
          end else if (below) begin
            lo_idx_q <= idx_m1;
            hi_idx_q <= idx_q;
          end else begin
            idx_q <= idx_m1;
          end
        end
        DONE: begin
          f1_o    <= frq[lo_idx_q];
          L1_o    <= acc[lo_idx_q];
          f2_o    <= frq[hi_idx_q];
          L2_o    <= acc[hi_idx_q];
          valid_o <= 1'b1;
          busy_o  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_find_bw_left_edge.sv
// Directed, table-driven bench for find_bw_left_edge.
module tb_find_bw_left_edge;

  localparam int N  = 24;
  localparam int AW = 18;
  localparam int FW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start;
  logic signed [AW-1:0] acc [N];
  logic        [FW-1:0] frq [N];
  logic        [FW-1:0] f1, f2;
  logic        [AW-1:0] l1, l2;
  logic                 valid, busy;

  int total = 0;
  int bad   = 0;

  find_bw_left_edge #(
    .ACCUM_WIDTH(AW), .FREQ_BIN_WIDTH(FW), .THRESHOLD_DB(7680), .NUM_ACCUMS(N)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .accumulator_val_i(acc), .freq_bin_i(frq),
    .f1_o(f1), .f2_o(f2), .L1_o(l1), .L2_o(l2),
    .valid_o(valid), .busy_o(busy)
  );

  typedef struct packed {
    logic [AW-1:0]      base;
    logic [2:0]         nov;
    logic [3:0][4:0]    oi;
    logic [3:0][AW-1:0] ov;
    logic               rev;
    logic [FW-1:0]      f1;
    logic [AW-1:0]      l1;
    logic [FW-1:0]      f2;
    logic [AW-1:0]      l2;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [AW-1:0] base, input int nov,
                              input int i0, input logic [AW-1:0] v0,
                              input int i1, input logic [AW-1:0] v1,
                              input int i2, input logic [AW-1:0] v2,
                              input int i3, input logic [AW-1:0] v3,
                              input logic rev,
                              input logic [FW-1:0] ef1, input logic [AW-1:0] el1,
                              input logic [FW-1:0] ef2, input logic [AW-1:0] el2);
    vec_t v;
    v.base  = base;
    v.nov   = 3'(nov);
    v.oi[0] = 5'(i0); v.ov[0] = v0;
    v.oi[1] = 5'(i1); v.ov[1] = v1;
    v.oi[2] = 5'(i2); v.ov[2] = v2;
    v.oi[3] = 5'(i3); v.ov[3] = v3;
    v.rev   = rev;
    v.f1 = ef1; v.l1 = el1; v.f2 = ef2; v.l2 = el2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < N; i++) begin
      acc[i] = v.base;
      frq[i] = v.rev ? FW'((N - 1 - i) * 16) : FW'(i * 16);
    end
    for (int j = 0; j < int'(v.nov); j++) acc[v.oi[j]] = v.ov[j];
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_result(input string nm, input vec_t v);
    chk({nm, " f1"}, 32'(f1), 32'(v.f1));
    chk({nm, " L1"}, 32'(l1), 32'(v.l1));
    chk({nm, " f2"}, 32'(f2), 32'(v.f2));
    chk({nm, " L2"}, 32'(l2), 32'(v.l2));
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    bit ok;
    load(v);
    pulse_start();
    chk({nm, " busy after start"}, 32'(busy), 32'd1);
    wait_valid(ok);
    chk({nm, " valid seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check_result(nm, v);
      chk({nm, " busy in valid cycle"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({nm, " valid one cycle"}, 32'(valid), 32'd0);
    end
  endtask

  initial begin
    bit ok;
    int pulses;

    // Records: base, overrides, reversed labels, expected f1/L1/f2/L2
    tbl[0] = mk(18'h3C400, 4, 12, 18'h00000, 11, 18'h3F600, 10, 18'h3EC00, 9, 18'h3D800,
                1'b0, 16'h0090, 18'h3D800, 16'h00A0, 18'h3EC00);
    tbl[1] = mk(18'h3C400, 1, 0, 18'h00000, 0, 0, 0, 0, 0, 0,
                1'b0, 16'h0000, 18'h00000, 16'h0000, 18'h00000);
    tbl[2] = mk(18'h3C400, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                1'b0, 16'h0000, 18'h3C400, 16'h0000, 18'h3C400);
    tbl[3] = mk(18'h3C400, 3, 5, 18'h00000, 4, 18'h3E200, 3, 18'h3E1FF, 0, 0,
                1'b0, 16'h0030, 18'h3E1FF, 16'h0040, 18'h3E200);
    tbl[4] = mk(18'h3C400, 2, 23, 18'h01000, 22, 18'h00000, 0, 0, 0, 0,
                1'b0, 16'h0150, 18'h3C400, 16'h0160, 18'h00000);
    tbl[5] = mk(18'h3C400, 2, 8, 18'h00000, 15, 18'h00000, 0, 0, 0, 0,
                1'b0, 16'h0070, 18'h3C400, 16'h0080, 18'h00000);
    tbl[6] = mk(18'h20000, 1, 10, 18'h20100, 0, 0, 0, 0, 0, 0,
                1'b0, 16'h0000, 18'h20000, 16'h0000, 18'h20000);
    tbl[7] = mk(18'h3C400, 1, 1, 18'h00000, 0, 0, 0, 0, 0, 0,
                1'b0, 16'h0000, 18'h3C400, 16'h0010, 18'h00000);
    tbl[8] = mk(18'h3C400, 4, 12, 18'h00000, 11, 18'h3F600, 10, 18'h3EC00, 9, 18'h3D800,
                1'b1, 16'h00E0, 18'h3D800, 16'h00D0, 18'h3EC00);
    tbl[9] = mk(18'h00000, 1, 20, 18'h1E000, 0, 0, 0, 0, 0, 0,
                1'b0, 16'h0130, 18'h00000, 16'h0140, 18'h1E000);

    rst = 1'b1;
    start = 1'b0;
    load(tbl[0]);
    repeat (3) @(negedge clk);
    chk("reset f1", 32'(f1), 32'd0);
    chk("reset f2", 32'(f2), 32'd0);
    chk("reset L1", 32'(l1), 32'd0);
    chk("reset L2", 32'(l2), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    for (int t = 0; t < 10; t++) run_vec($sformatf("vec%0d", t), tbl[t]);

    // Reset in the middle of a scan: no result, outputs cleared, then recovery
    load(tbl[0]);
    pulse_start();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst f1", 32'(f1), 32'd0);
    chk("midrst f2", 32'(f2), 32'd0);
    chk("midrst L1", 32'(l1), 32'd0);
    chk("midrst L2", 32'(l2), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("midrst no valid", 32'(pulses), 32'd0);
    run_vec("after reset", tbl[0]);

    // Start while busy must not produce a second result
    load(tbl[3]);
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("busy start pulses", 32'(pulses), 32'd1);
    check_result("busy start", tbl[3]);

    // Back-to-back: start during the valid cycle is deferred by one cycle
    load(tbl[4]);
    pulse_start();
    wait_valid(ok);
    chk("b2b first valid", 32'(ok), 32'd1);
    check_result("b2b first", tbl[4]);
    chk("b2b first busy", 32'(busy), 32'd0);
    load(tbl[5]);
    start = 1'b1;
    @(negedge clk);
    chk("b2b start ignored", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b start taken", 32'(busy), 32'd1);
    wait_valid(ok);
    chk("b2b second valid", 32'(ok), 32'd1);
    check_result("b2b second", tbl[5]);
    chk("b2b second busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/find_bw_left_edge.md
Name: find_bw_left_edge

Overview:
- Spectral-analysis helper that locates the lower (left) edge of a signal's occupied bandwidth.
- Scans NUM_ACCUMS signed power values (dB, Q8.8) with their frequency-bin labels and finds the peak.
- Walks left from the peak to the first bin lying more than THRESHOLD_DB below it.
- Reports the two bins bracketing that crossing (f1/L1 below threshold, f2/L2 at or above it) for a downstream interpolator.

Parameters:
- ACCUM_WIDTH, 18: width of each signed power value (two's complement, Q(ACCUM_WIDTH-8).8 dB).
- FREQ_BIN_WIDTH, 16: width of each unsigned frequency-bin label.
- THRESHOLD_DB, 7680: positive drop below peak that defines the edge, same Q8.8 format (7680 = 30.0 dB).
- NUM_ACCUMS, 24: number of bins; must be >= 2.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start pulse, sampled when idle
- accumulator_val_i  in  NUM_ACCUMS x ACCUM_WIDTH signed (unpacked array)  power per bin, index 0 = lowest frequency
- freq_bin_i  in  NUM_ACCUMS x FREQ_BIN_WIDTH (unpacked array)  frequency label per bin
- f1_o  out  FREQ_BIN_WIDTH  frequency of first bin below threshold
- f2_o  out  FREQ_BIN_WIDTH  frequency of its right neighbour
- L1_o  out  ACCUM_WIDTH signed  power at f1
- L2_o  out  ACCUM_WIDTH signed  power at f2
- valid_o  out  1  one-cycle result strobe
- busy_o  out  1  high from start acceptance until valid_o is issued

Behaviour:
- Reset (rst_i=1 at a clock edge, including mid-operation): FSM -> IDLE; f1_o, f2_o, L1_o, L2_o, valid_o, busy_o = 0; internal index and peak registers cleared.
- IDLE: busy_o=0. When start_i=1, capture index 0 as the running peak, set index to 1, go to PEAK, and assert busy_o from the next cycle.
- PEAK: one bin per cycle. A bin replaces the running peak only if strictly greater, so ties keep the lowest index. After index NUM_ACCUMS-1, compute thr = peak - THRESHOLD_DB at ACCUM_WIDTH+1 bits signed (no wrap), set index = peak_idx, go to SEARCH.
- SEARCH:
  - If index = 0, no crossing exists: go to DONE with the fallback result.
  - Otherwise examine bin index-1. If it is strictly less than thr, latch f1=freq[index-1], L1=acc[index-1], f2=freq[index], L2=acc[index] and go to DONE; else decrement index.
- Fallback result (peak at bin 0, or nothing falls below thr): f1=f2=freq[0], L1=L2=acc[0].
- DONE: drive result registers, pulse valid_o=1 for exactly one cycle, clear busy_o in the same cycle, return to IDLE.
- Outputs hold their last result until the next DONE or a reset.
- Latency from the start edge to valid_o: NUM_ACCUMS + (peak_idx - k) + 1 cycles, where k is the crossing index. Worst case is about 2*NUM_ACCUMS + 1.
- start_i is ignored while busy_o=1. A start in the same cycle as valid_o is also ignored; it is accepted the cycle after.
- Without the optional feature, inputs must stay stable from start until valid_o.
- All comparisons are signed. Frequency labels are passed through untouched and need not be monotonic.

Optional Feature:
- Macro FIND_BW_LEFT_EDGE_SNAPSHOT_EN.
- Defined: on start acceptance, both input arrays are copied into internal registers, and the whole scan uses the copy. Inputs may change freely once start is accepted. Latency is unchanged.
- Undefined: no copy registers; inputs are read live and must stay stable while busy_o=1.

Test Plan:
- Nominal: freq[i]=i*0x10, all bins -60 dB (0x3C400); bin12=0x00000, bin11=-10 dB (0x3F600), bin10=-20 dB (0x3EC00), bin9=-40 dB (0x3D800) -> one valid pulse with f1=0x90, L1=0x3D800, f2=0xA0, L2=0x3EC00.
- Peak at bin 0 = 0x00000, rest -60 dB -> fallback f1=f2=0x00, L1=L2=0x00000.
- All bins equal 0x3C400 (no crossing, tie resolves to bin 0) -> fallback f1=f2=0x00, L1=L2=0x3C400.
- Exact threshold: peak 0 at bin 5, bin4 = -7680 (0x3E200), bin3 = -7681 (0x3E1FF) -> f1=0x30, L1=0x3E1FF, f2=0x40, L2=0x3E200, proving the comparison is strictly less-than.
- Robustness: assert rst_i mid-scan -> valid_o never pulses, all outputs 0; then a new start yields the nominal result. A start pulse while busy_o=1 -> no extra valid pulse.
- Back-to-back: two consecutive starts with different vectors -> each valid pulse carries its own correct result, and busy_o deasserts in the valid cycle.
